// File: rtl/bcd_counter_nd.sv
// bcd_counter_nd: N-digit BCD up/down counter with parallel load,
// terminal-count flag and selectable halt/wrap behaviour at the boundary.
// Q is a packed BCD bus, digit k at [4k+3:4k], digit 0 least significant.
module bcd_counter_nd #(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d_in,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  ceo,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    // True when every nibble of v is a legal BCD digit (0..9).
    function automatic logic all_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            ok = ok & (v[4*k +: 4] <= 4'd9);
        end
        return ok;
    endfunction

    // True when every nibble of v equals val.
    function automatic logic all_digits(input logic [W-1:0] v, input logic [3:0] val);
        logic eq;
        eq = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            eq = eq & (v[4*k +: 4] == val);
        end
        return eq;
    endfunction

    logic [W-1:0] q_r;
    logic         ovf_r;
    logic         load_err_r;

    logic         ceo_s;
    logic [W-1:0] next_count_s;
    logic         load_ok_s;

    // Terminal count depends on the live direction so it follows 'up' without waiting a clock.
    always_comb begin
        ceo_s = 1'b0;
        if (up) begin
            ceo_s = all_digits(q_r, 4'd9);
        end else begin
            ceo_s = all_digits(q_r, 4'd0);
        end
    end

    // Ripple the carry/borrow chain: a digit steps only when all lower digits sit at their terminal value.
    always_comb begin
        logic       chain_s;
        logic [3:0] digit_s;
        next_count_s = q_r;
        chain_s      = 1'b1;
        digit_s      = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            digit_s = q_r[4*k +: 4];
            if (chain_s) begin
                if (up) begin
                    next_count_s[4*k +: 4] = (digit_s == 4'd9) ? 4'd0 : digit_s + 4'd1;
                end else begin
                    next_count_s[4*k +: 4] = (digit_s == 4'd0) ? 4'd9 : digit_s - 4'd1;
                end
            end else begin
                next_count_s[4*k +: 4] = digit_s;
            end
            chain_s = chain_s & (digit_s == (up ? 4'd9 : 4'd0));
        end
    end

    // A load is only accepted when it cannot put a non-BCD nibble into the count.
    always_comb begin
        load_ok_s = all_bcd(d_in);
    end

    // Count state and the two one-cycle status pulses; priority is reset > load > enable > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r        <= {W{1'b0}};
            ovf_r      <= 1'b0;
            load_err_r <= 1'b0;
        end else if (load) begin
            ovf_r <= 1'b0;
            if (load_ok_s) begin
                q_r        <= d_in;
                load_err_r <= 1'b0;
            end else begin
                q_r        <= q_r;
                load_err_r <= 1'b1;
            end
        end else if (enable) begin
            load_err_r <= 1'b0;
            if (ceo_s) begin
                // At the boundary: either saturate or let the chain roll every digit over.
                ovf_r <= 1'b1;
                if (WRAP) begin
                    q_r <= next_count_s;
                end else begin
                    q_r <= q_r;
                end
            end else begin
                ovf_r <= 1'b0;
                q_r   <= next_count_s;
            end
        end else begin
            q_r        <= q_r;
            ovf_r      <= 1'b0;
            load_err_r <= 1'b0;
        end
    end

    assign Q        = q_r;
    assign ceo      = ceo_s;
    assign ovf      = ovf_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Testbench for bcd_counter_nd: a halting and a wrapping 3-digit instance share
// the stimulus; each vector names which instance it checks and what it expects.
module tb_bcd_counter_nd;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [11:0] d_in = 12'h000;

    logic [11:0] q_h, q_w;
    logic        ceo_h, ceo_w, ovf_h, ovf_w, lerr_h, lerr_w;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          sel_wrap;
        bit          chk_q;
        logic [11:0] q;
        bit          chk_ceo;
        bit          ceo;
        bit          ovf;
        bit          lerr;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    bcd_counter_nd #(.DIGITS(3), .WRAP(1'b0)) dut_halt (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .d_in(d_in), .Q(q_h), .ceo(ceo_h), .ovf(ovf_h), .load_err(lerr_h)
    );

    bcd_counter_nd #(.DIGITS(3), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .d_in(d_in), .Q(q_w), .ceo(ceo_w), .ovf(ovf_w), .load_err(lerr_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and queue what must follow the next rising edge.
    task automatic vec(input bit rst, input bit ld, input bit en, input bit u,
                       input logic [11:0] d, input bit sel, input bit cq,
                       input logic [11:0] eq, input bit cc, input bit ec,
                       input bit eo, input bit el, input string nm);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        load   = ld;
        enable = en;
        up     = u;
        d_in   = d;
        e.sel_wrap = sel;
        e.chk_q    = cq;
        e.q        = eq;
        e.chk_ceo  = cc;
        e.ceo      = ec;
        e.ovf      = eo;
        e.lerr     = el;
        e.name     = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: the counter presents a result every cycle, so pop one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.sel_wrap) begin
                    if (e.chk_q)   check({e.name, ".q"},   q_w, e.q);
                    if (e.chk_ceo) check({e.name, ".ceo"}, {11'd0, ceo_w}, {11'd0, e.ceo});
                    check({e.name, ".ovf"},  {11'd0, ovf_w},  {11'd0, e.ovf});
                    check({e.name, ".lerr"}, {11'd0, lerr_w}, {11'd0, e.lerr});
                end else begin
                    if (e.chk_q)   check({e.name, ".q"},   q_h, e.q);
                    if (e.chk_ceo) check({e.name, ".ceo"}, {11'd0, ceo_h}, {11'd0, e.ceo});
                    check({e.name, ".ovf"},  {11'd0, ovf_h},  {11'd0, e.ovf});
                    check({e.name, ".lerr"}, {11'd0, lerr_h}, {11'd0, e.lerr});
                end
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        int drain;
        //   rst ld en up d        sel cq q        cc ceo ovf lerr name
        // Reset with enable high clears both instances.
        vec(1, 0, 1, 1, 12'h000, 0, 1, 12'h000, 1, 0, 0, 0, "reset_halt");
        vec(1, 0, 1, 1, 12'h000, 1, 1, 12'h000, 1, 0, 0, 0, "reset_wrap");
        // Carry across two digits and borrow back.
        vec(0, 1, 0, 1, 12'h199, 0, 1, 12'h199, 1, 0, 0, 0, "load_199");
        vec(0, 0, 1, 1, 12'h000, 0, 1, 12'h200, 1, 0, 0, 0, "up_200");
        vec(0, 0, 1, 0, 12'h000, 0, 1, 12'h199, 1, 0, 0, 0, "down_199");
        // Halt mode saturates at 999 and pulses ovf every attempt.
        vec(0, 1, 0, 1, 12'h999, 0, 1, 12'h999, 1, 1, 0, 0, "load_999");
        vec(0, 0, 1, 1, 12'h000, 0, 1, 12'h999, 1, 1, 1, 0, "sat_1");
        vec(0, 0, 1, 1, 12'h000, 0, 1, 12'h999, 1, 1, 1, 0, "sat_2");
        vec(0, 0, 1, 1, 12'h000, 0, 1, 12'h999, 1, 1, 1, 0, "sat_3");
        vec(0, 0, 0, 1, 12'h000, 0, 1, 12'h999, 1, 1, 0, 0, "sat_hold");
        // Wrap mode: borrow from 000 rolls to 999 with one ovf pulse.
        vec(0, 1, 0, 0, 12'h000, 1, 1, 12'h000, 1, 1, 0, 0, "load_000");
        vec(0, 0, 1, 0, 12'h000, 1, 1, 12'h999, 1, 0, 1, 0, "wrap_down");
        vec(0, 0, 0, 0, 12'h000, 1, 1, 12'h999, 1, 0, 0, 0, "wrap_hold");
        // Same count, direction flipped: terminal flag follows 'up'.
        vec(0, 0, 0, 1, 12'h000, 1, 1, 12'h999, 1, 1, 0, 0, "ceo_up");
        // Rejected loads keep Q and pulse load_err once.
        vec(0, 1, 0, 1, 12'h123, 0, 1, 12'h123, 1, 0, 0, 0, "load_123");
        vec(0, 1, 0, 1, 12'h1A3, 0, 1, 12'h123, 1, 0, 0, 1, "bad_1a3");
        vec(0, 0, 0, 1, 12'h000, 0, 1, 12'h123, 1, 0, 0, 0, "bad_clear");
        vec(0, 1, 0, 1, 12'hB00, 0, 1, 12'h123, 1, 0, 0, 1, "bad_b00");
        vec(0, 1, 1, 0, 12'h99A, 0, 1, 12'h123, 1, 0, 0, 1, "bad_99a");
        vec(0, 1, 1, 1, 12'h042, 0, 1, 12'h042, 1, 0, 0, 0, "load_en_042");
        // Load wins over a terminal-count step: no ovf.
        vec(0, 1, 0, 1, 12'h999, 0, 1, 12'h999, 1, 1, 0, 0, "load_999b");
        vec(0, 1, 1, 1, 12'h500, 0, 1, 12'h500, 1, 0, 0, 0, "load_at_term");
        // Reset beats load and enable mid-count.
        vec(0, 1, 0, 1, 12'h537, 1, 1, 12'h537, 1, 0, 0, 0, "load_537");
        vec(1, 1, 1, 1, 12'h537, 1, 1, 12'h000, 1, 0, 0, 0, "reset_mid");
        // Free run: 1000 up steps return to 000 with a single ovf on the last step.
        for (int k = 1; k <= 1000; k++) begin
            vec(0, 0, 1, 1, 12'h000, 1, (k == 999) || (k == 1000),
                (k == 999) ? 12'h999 : 12'h000, (k == 999), 1'b1,
                (k == 1000), 0, "freerun");
        end
        vec(0, 0, 0, 1, 12'h000, 1, 1, 12'h000, 1, 0, 0, 0, "freerun_end");

        drain = 0;
        while (sb_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            #2;
            drain++;
        end
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL check_count: got %0d comparisons, required at least 12", n_checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
